// File: rtl/seq_det_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_det_pkg                                                      |
// | Purpose  : Shared defaults and helpers for the parametrised seq detector.   |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package seq_det_pkg;

    localparam int c_DEF_DATA_W  = 3;
    localparam int c_DEF_SEQ_LEN = 7;
    localparam int c_DEF_CNT_W   = 16;

    // Symbol 0 (first expected) in the LSBs: 1,5,6,0,6,6,3
    localparam logic [c_DEF_SEQ_LEN*c_DEF_DATA_W-1:0] c_DEF_RESET_PATTERN = 21'h0F61A9;

    typedef logic [c_DEF_DATA_W-1:0] sym_t;

    function automatic logic [c_DEF_SEQ_LEN*c_DEF_DATA_W-1:0] pack_pattern(
        input sym_t syms [c_DEF_SEQ_LEN]
    );
        logic [c_DEF_SEQ_LEN*c_DEF_DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < c_DEF_SEQ_LEN; i++) begin
            v[i*c_DEF_DATA_W +: c_DEF_DATA_W] = syms[i];
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_history.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_det_history                                                  |
// | Purpose  : Symbol history shift register with saturating fill counter.      |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module seq_det_history
    import seq_det_pkg::*;
#(
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int SEQ_LEN = c_DEF_SEQ_LEN
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      shift_en,
    input  logic                      flush,
    input  logic [DATA_W-1:0]         din,
    output logic [SEQ_LEN*DATA_W-1:0] hist,
    output logic                      fill_ok
);

    localparam int                  c_FILL_W   = $clog2(SEQ_LEN + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(SEQ_LEN);
    localparam logic [c_FILL_W-1:0] c_FILL_THR = c_FILL_W'(SEQ_LEN - 1);

    logic [SEQ_LEN*DATA_W-1:0] r_hist;
    logic [c_FILL_W-1:0]       r_fill;

    // Newest symbol enters at the top slot; slot 0 holds the oldest.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
        end else begin
            if (shift_en) begin
                r_hist <= {din, r_hist[SEQ_LEN*DATA_W-1:DATA_W]};
            end
            if (flush) begin
                r_fill <= '0;
            end else if (shift_en && (r_fill != c_FILL_MAX)) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    assign hist    = r_hist;
    assign fill_ok = (r_fill >= c_FILL_THR);

endmodule
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_detector_param                                               |
// | Purpose  : Programmable symbol-sequence detector with overlap mode and      |
// |            saturating match counter. Optional macro SEQ_DET_MASK_EN adds    |
// |            per-position don't-care masking (pat_mask input).                |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                          DATA_W        = c_DEF_DATA_W,
    parameter int                          SEQ_LEN       = c_DEF_SEQ_LEN,
    parameter int                          CNT_W         = c_DEF_CNT_W,
    parameter logic [SEQ_LEN*DATA_W-1:0]   RESET_PATTERN = c_DEF_RESET_PATTERN
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            data,
    input  logic                         data_valid,
    input  logic                         overlap,
    input  logic                         pat_we,
    input  logic [$clog2(SEQ_LEN)-1:0]   pat_idx,
    input  logic [DATA_W-1:0]            pat_data,
`ifdef SEQ_DET_MASK_EN
    input  logic                         pat_mask,
`endif
    input  logic                         cnt_clr,
    output logic                         sequence_found,
    output logic [CNT_W-1:0]             match_count
);

    localparam int c_IDX_W = $clog2(SEQ_LEN);
    localparam int c_VEC_W = SEQ_LEN * DATA_W;

    logic [c_VEC_W-1:0] r_pattern;
`ifdef SEQ_DET_MASK_EN
    logic [SEQ_LEN-1:0] r_mask;
`endif
    logic [c_VEC_W-1:0] w_hist;
    logic [c_VEC_W-1:0] w_window;
    logic [SEQ_LEN-1:0] w_pos_eq;
    logic               w_fill_ok;
    logic               w_accept;
    logic               w_match;
    logic               w_flush;
    logic               w_unused_oldest;
    logic               r_found;
    logic [CNT_W-1:0]   r_count;

    // A pattern write takes the cycle: the symbol is dropped and no match is evaluated.
    assign w_accept = data_valid & ~pat_we;
    assign w_flush  = pat_we | (w_match & ~overlap);

    seq_det_history #(
        .DATA_W  (DATA_W),
        .SEQ_LEN (SEQ_LEN)
    ) u_history (
        .clk      (clk),
        .reset    (reset),
        .shift_en (w_accept),
        .flush    (w_flush),
        .din      (data),
        .hist     (w_hist),
        .fill_ok  (w_fill_ok)
    );

    // The oldest stored symbol is about to fall out, so it never takes part in a match.
    assign w_window        = {data, w_hist[c_VEC_W-1:DATA_W]};
    assign w_unused_oldest = ^w_hist[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern <= RESET_PATTERN;
`ifdef SEQ_DET_MASK_EN
            r_mask    <= '0;
`endif
        end else if (pat_we) begin
            for (int j = 0; j < SEQ_LEN; j++) begin
                if (pat_idx == c_IDX_W'(j)) begin
                    r_pattern[j*DATA_W +: DATA_W] <= pat_data;
`ifdef SEQ_DET_MASK_EN
                    r_mask[j]                     <= pat_mask;
`endif
                end
            end
        end
    end

    generate
        for (genvar j = 0; j < SEQ_LEN; j++) begin : g_cmp
`ifdef SEQ_DET_MASK_EN
            assign w_pos_eq[j] = r_mask[j] |
                                 (w_window[j*DATA_W +: DATA_W] == r_pattern[j*DATA_W +: DATA_W]);
`else
            assign w_pos_eq[j] = (w_window[j*DATA_W +: DATA_W] == r_pattern[j*DATA_W +: DATA_W]);
`endif
        end
    endgenerate

    assign w_match = w_accept & w_fill_ok & (&w_pos_eq);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_found <= 1'b0;
            r_count <= '0;
        end else begin
            r_found <= w_match;
            if (cnt_clr) begin
                r_count <= '0;
            end else if (w_match && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign sequence_found = r_found;
    assign match_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_detector_param                                            |
// | Purpose  : Self-checking bench for seq_detector_param (default and CNT_W=2  |
// |            instances); honours SEQ_DET_MASK_EN when defined.                |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_seq_detector_param;

`ifdef SEQ_DET_MASK_EN
    localparam bit c_MASK_EN = 1'b1;
`else
    localparam bit c_MASK_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [2:0] data;
    logic       data_valid;
    logic       overlap;
    logic       pat_we;
    logic [2:0] pat_idx;
    logic [2:0] pat_data;
    logic       pat_mask;
    logic       cnt_clr;
    logic       found_a;
    logic       found_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int errors = 0;
    int checks = 0;

    // Reference model: pattern/mask arrays and a queue of the last accepted symbols since a flush.
    int unsigned m_pat [7];
    bit          m_mask [7];
    int unsigned m_hist [$];
    bit          m_found;
    int unsigned m_cnt_a;
    int unsigned m_cnt_b;

    int seq_def [7] = '{1, 5, 6, 0, 6, 6, 3};
    int seq_alt [7] = '{1, 5, 6, 0, 6, 6, 4};
    int seq_msk [7] = '{1, 5, 6, 7, 6, 6, 3};

    seq_detector_param u_dut (
        .clk            (clk),
        .reset          (reset),
        .data           (data),
        .data_valid     (data_valid),
        .overlap        (overlap),
        .pat_we         (pat_we),
        .pat_idx        (pat_idx),
        .pat_data       (pat_data),
`ifdef SEQ_DET_MASK_EN
        .pat_mask       (pat_mask),
`endif
        .cnt_clr        (cnt_clr),
        .sequence_found (found_a),
        .match_count    (cnt_a)
    );

    seq_detector_param #(.CNT_W(2)) u_sat (
        .clk            (clk),
        .reset          (reset),
        .data           (data),
        .data_valid     (data_valid),
        .overlap        (overlap),
        .pat_we         (pat_we),
        .pat_idx        (pat_idx),
        .pat_data       (pat_data),
`ifdef SEQ_DET_MASK_EN
        .pat_mask       (pat_mask),
`endif
        .cnt_clr        (cnt_clr),
        .sequence_found (found_b),
        .match_count    (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit hit;
        hit = 1'b0;
        if (reset) begin
            m_pat   = '{1, 5, 6, 0, 6, 6, 3};
            m_mask  = '{default: 1'b0};
            m_hist.delete();
            m_cnt_a = 0;
            m_cnt_b = 0;
            m_found = 1'b0;
            return;
        end
        if (pat_we) begin
            if (pat_idx < 7) begin
                m_pat[pat_idx]  = pat_data;
                m_mask[pat_idx] = c_MASK_EN ? pat_mask : 1'b0;
            end
            m_hist.delete();
        end else if (data_valid) begin
            if (m_hist.size() >= 6) begin
                hit = 1'b1;
                for (int k = 0; k < 7; k++) begin
                    int unsigned sym;
                    sym = (k < 6) ? m_hist[k] : int'(data);
                    if (!m_mask[k] && sym != m_pat[k]) hit = 1'b0;
                end
            end
            if (hit && !overlap) begin
                m_hist.delete();
            end else begin
                m_hist.push_back(int'(data));
                if (m_hist.size() > 6) void'(m_hist.pop_front());
            end
        end
        m_found = hit;
        if (cnt_clr) begin
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (hit) begin
            if (m_cnt_a < 65535) m_cnt_a++;
            if (m_cnt_b < 3) m_cnt_b++;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("found_a", {31'b0, found_a}, {31'b0, m_found});
        check("found_b", {31'b0, found_b}, {31'b0, m_found});
        check("count_a", {16'b0, cnt_a}, m_cnt_a);
        check("count_b", {30'b0, cnt_b}, m_cnt_b);
    endtask

    task automatic feed(input int d);
        reset      = 1'b0;
        pat_we     = 1'b0;
        cnt_clr    = 1'b0;
        data_valid = 1'b1;
        data       = 3'(d);
        tick();
    endtask

    task automatic idle();
        reset      = 1'b0;
        pat_we     = 1'b0;
        cnt_clr    = 1'b0;
        data_valid = 1'b0;
        tick();
    endtask

    task automatic clr();
        reset      = 1'b0;
        pat_we     = 1'b0;
        data_valid = 1'b0;
        cnt_clr    = 1'b1;
        tick();
        cnt_clr    = 1'b0;
    endtask

    task automatic wr(input int idx, input int d, input bit m);
        reset      = 1'b0;
        data_valid = 1'b0;
        cnt_clr    = 1'b0;
        pat_we     = 1'b1;
        pat_idx    = 3'(idx);
        pat_data   = 3'(d);
        pat_mask   = m;
        tick();
        pat_we     = 1'b0;
        pat_mask   = 1'b0;
    endtask

    task automatic feed_seq(input int s [7], input int n);
        for (int i = 0; i < n; i++) feed(s[i]);
    endtask

    initial begin
        reset = 1'b1; data = '0; data_valid = 1'b0; overlap = 1'b0;
        pat_we = 1'b0; pat_idx = '0; pat_data = '0; pat_mask = 1'b0; cnt_clr = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset_found", {31'b0, found_a}, 32'd0);
        check("reset_count", {16'b0, cnt_a}, 32'd0);

        // Default pattern, non-overlapping
        feed_seq(seq_def, 7);
        check("default_pulse", {31'b0, found_a}, 32'd1);
        idle();
        check("default_count", {16'b0, cnt_a}, 32'd1);

        // Same sequence with two invalid cycles after the 0
        feed_seq(seq_def, 4);
        idle();
        idle();
        feed(6); feed(6); feed(3);
        check("gap_pulse", {31'b0, found_a}, 32'd1);
        check("gap_count", {16'b0, cnt_a}, 32'd2);

        // All-2 pattern: overlap on, then off
        clr();
        for (int i = 0; i < 7; i++) wr(i, 2, 1'b0);
        overlap = 1'b1;
        for (int i = 0; i < 9; i++) feed(2);
        check("overlap_count", {16'b0, cnt_a}, 32'd3);
        wr(7, 5, 1'b0);
        clr();
        overlap = 1'b0;
        for (int i = 0; i < 9; i++) feed(2);
        check("nonoverlap_count", {16'b0, cnt_a}, 32'd1);

        // Write collides with the final symbol
        for (int i = 0; i < 7; i++) wr(i, seq_def[i], 1'b0);
        clr();
        feed_seq(seq_def, 6);
        data_valid = 1'b1; data = 3'd3;
        pat_we = 1'b1; pat_idx = 3'd6; pat_data = 3'd4;
        tick();
        pat_we = 1'b0;
        check("collision_nopulse", {31'b0, found_a}, 32'd0);
        feed_seq(seq_alt, 7);
        check("collision_after", {16'b0, cnt_a}, 32'd1);

        // Saturation in the 2-bit instance, then clear coinciding with a match
        clr();
        for (int r = 0; r < 5; r++) feed_seq(seq_alt, 7);
        check("sat_count_a", {16'b0, cnt_a}, 32'd5);
        check("sat_count_b", {30'b0, cnt_b}, 32'd3);
        feed_seq(seq_alt, 6);
        data_valid = 1'b1; data = 3'd4; cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_hit_found", {31'b0, found_b}, 32'd1);
        check("clr_hit_count", {30'b0, cnt_b}, 32'd0);

        // Reset lands on the match cycle: pulse lost
        feed_seq(seq_alt, 6);
        reset = 1'b1; data_valid = 1'b1; data = 3'd4;
        tick();
        check("midreset_found", {31'b0, found_a}, 32'd0);
        idle();

        // Position 3 marked don't-care (only effective with the mask feature)
        wr(3, 0, 1'b1);
        feed_seq(seq_msk, 7);
        check("mask_pulse", {31'b0, found_a}, {31'b0, c_MASK_EN});
        idle();

        // Randomised traffic over a binary pattern to make matches frequent
        for (int i = 0; i < 7; i++) wr(i, int'($urandom_range(0, 1)), 1'b0);
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 1499) == 0);
            pat_we     = ($urandom_range(0, 63) == 0);
            pat_idx    = 3'($urandom_range(0, 7));
            pat_data   = 3'($urandom_range(0, 1));
            pat_mask   = ($urandom_range(0, 7) == 0);
            data_valid = ($urandom_range(0, 3) != 0);
            data       = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7))
                                                      : 3'($urandom_range(0, 1));
            cnt_clr    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) overlap = ~overlap;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
